// File: rtl/tri_input_fifo_if.sv
// Triangle handshake bundle: position, color, valid forward; active-low halt backward.
// The master drives the triangle, and the slave drives halt.
interface tri_input_fifo_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_R10U;
  logic                                          validTri_R10H;
  logic                                          halt_RnnnnL;

  modport master (output tri_R10S, color_R10U, validTri_R10H, input  halt_RnnnnL);
  modport slave  (input  tri_R10S, color_R10U, validTri_R10H, output halt_RnnnnL);
endinterface

// File: rtl/tri_input_fifo.sv
// Circular-buffer FIFO of triangles between the rasterizer input and bbox, with registered head outputs.
// Optional statistics counters are enabled by defining TRI_FIFO_STATS_EN.
module tri_input_fifo #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  tri_input_fifo_if.slave  upstream,
  tri_input_fifo_if.master bbox,
  output logic [31:0]      tri_count_RnnnnU,
  output logic [31:0]      stall_count_RnnnnU
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 2;
  localparam int CW = AW + 1;

  typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic        [COLORS-1:0][SIGFIG-1:0]          color_t;
  typedef struct packed {
    tri_t   tri_v;
    color_t color;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry, head_q, head_next;
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_next, rd_next;
  logic [CW-1:0]   count, count_next;
  logic            valid_q, halt_q;
  logic            push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_entry = '{tri_v: upstream.tri_R10S, color: upstream.color_R10U};

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    push       = upstream.validTri_R10H & halt_q & rst;
    pop        = valid_q & bbox.halt_RnnnnL & rst;
    wr_next    = push ? ptr_inc(wr_ptr) : wr_ptr;
    rd_next    = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    count_next = count;
    head_next  = head_q;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
    // New head comes straight from the input when it lands in an otherwise empty buffer.
    if (count_next != '0) begin
      if (push && (count == CW'(pop))) head_next = in_entry;
      else                             head_next = mem[rd_next[AW-1:0]];
    end
  end

  // NOTE: storage has no reset; only pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b1;
      head_q  <= '0;
    end else begin
      wr_ptr  <= wr_next;
      rd_ptr  <= rd_next;
      count   <= count_next;
      valid_q <= (count_next != '0);
      halt_q  <= (count_next != CW'(DEPTH));
      head_q  <= head_next;
    end
  end

  assign upstream.halt_RnnnnL = halt_q;
  assign bbox.tri_R10S        = head_q.tri_v;
  assign bbox.color_R10U      = head_q.color;
  assign bbox.validTri_R10H   = valid_q;

`ifdef TRI_FIFO_STATS_EN
  logic [31:0] tri_cnt, stall_cnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tri_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (push && (tri_cnt != '1)) tri_cnt <= tri_cnt + 32'd1;
      if (upstream.validTri_R10H && !halt_q && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign tri_count_RnnnnU   = tri_cnt;
  assign stall_count_RnnnnU = stall_cnt;
`else
  assign tri_count_RnnnnU   = '0;
  assign stall_count_RnnnnU = '0;
`endif
endmodule
